// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants (transmit FSM states, parity modes)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_ARMED  = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Tick-paced UART transmitter, LSB first, optional parity, 1/2 stop
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 t_clk,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                c_CNT_W     = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(DATA_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_ONE  = c_CNT_W'(1);
    localparam logic              c_STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_done;

    logic w_tick;
    logic w_ready;
    logic w_accept;

    assign w_tick   = t_clk & tx_en;
    assign w_ready  = (r_state == TX_IDLE) & tx_en & ~reset;
    assign w_accept = tx_valid & w_ready;

    always_ff @(posedge clk_in) begin
        r_done <= 1'b0;
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= tx_data;
                        r_par   <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                        r_state <= TX_ARMED;
                    end
                end
                TX_ARMED: begin
                    if (w_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                r_tx    <= r_par;
                                r_state <= TX_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= TX_STOP;
                            end
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == c_STOP_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= TX_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = w_ready;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != TX_IDLE);
    assign tx_done  = r_done;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Directed self-checking bench for uart_tx (8N1, 8E1, 8O1, 7N2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       r_reset;
    logic       r_t_clk = 1'b0;
    logic [1:0] r_t_cnt = 2'd0;
    logic       r_tx_en;
    logic [7:0] r_data;
    logic [3:0] r_valid;
    logic [3:0] w_ready;
    logic [3:0] w_tx;
    logic [3:0] w_busy;
    logic [3:0] w_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic trace [0:127];
    int   ready_cnt;
    int   done_cnt;
    int   done_at;
    logic busy_mid;

    always #5 clk = ~clk;

    // One-cycle bit tick every fourth clock.
    always @(posedge clk) begin
        r_t_cnt <= r_t_cnt + 2'd1;
        r_t_clk <= (r_t_cnt == 2'd3);
    end

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_in(clk), .reset(r_reset), .t_clk(r_t_clk), .tx_en(r_tx_en),
        .tx_data(r_data), .tx_valid(r_valid[0]), .tx_ready(w_ready[0]),
        .tx(w_tx[0]), .tx_busy(w_busy[0]), .tx_done(w_done[0]));

    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk_in(clk), .reset(r_reset), .t_clk(r_t_clk), .tx_en(r_tx_en),
        .tx_data(r_data), .tx_valid(r_valid[1]), .tx_ready(w_ready[1]),
        .tx(w_tx[1]), .tx_busy(w_busy[1]), .tx_done(w_done[1]));

    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk_in(clk), .reset(r_reset), .t_clk(r_t_clk), .tx_en(r_tx_en),
        .tx_data(r_data), .tx_valid(r_valid[2]), .tx_ready(w_ready[2]),
        .tx(w_tx[2]), .tx_busy(w_busy[2]), .tx_done(w_done[2]));

    uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk_in(clk), .reset(r_reset), .t_clk(r_t_clk), .tx_en(r_tx_en),
        .tx_data(r_data[6:0]), .tx_valid(r_valid[3]), .tx_ready(w_ready[3]),
        .tx(w_tx[3]), .tx_busy(w_busy[3]), .tx_done(w_done[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input bit hold);
        int w;
        @(negedge clk);
        r_data     = d;
        r_valid[k] = 1'b1;
        w = 0;
        while (w_ready[k] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(w < 200), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) r_valid[k] = 1'b0;
    endtask

    task automatic wait_fall(input int k, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            if (w_tx[k] === 1'b0) ok = 1'b1;
        end
    endtask

    // Offset 0 is the first negedge showing the start bit.
    task automatic capture(input int k, input int n);
        bit ok;
        wait_fall(k, ok);
        check("fall_seen", 32'(ok), 32'd1);
        ready_cnt = 0;
        done_cnt  = 0;
        done_at   = -1;
        busy_mid  = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            trace[c] = w_tx[k];
            if (w_ready[k] === 1'b1) ready_cnt++;
            if (w_done[k] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 2) busy_mid = w_busy[k];
        end
    endtask

    function automatic logic [31:0] frame_bits(input int base, input int nbits);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nbits; i++) v[i] = trace[base + 4*i + 2];
        return v;
    endfunction

    function automatic int pause_point(input int i);
        return (i <= 4) ? (2 + 4*i) : (22 + 4*i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          hold_err;
        int          low_cnt;
        logic [31:0] obs;
        logic        pause_busy;

        r_reset = 1'b1;
        r_tx_en = 1'b1;
        r_valid = 4'b0000;
        r_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx",    32'(w_tx),    32'hF);
        check("rst_busy",  32'(w_busy),  32'h0);
        check("rst_done",  32'(w_done),  32'h0);
        check("rst_ready", 32'(w_ready), 32'h0);
        r_reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(w_ready), 32'hF);
        check("idle_tx",    32'(w_tx),    32'hF);

        // 8N1, 0xA5
        send(0, 8'hA5, 1'b0);
        capture(0, 44);
        check("8n1_bits",     frame_bits(0, 10), 32'({1'b1, 8'hA5, 1'b0}));
        check("8n1_done_at",  done_at,  32'd40);
        check("8n1_done_cnt", done_cnt, 32'd1);
        check("8n1_busy",     32'(busy_mid), 32'd1);

        // 8E1 and 8O1, 0xA5 (four ones: even bit 0, odd bit 1)
        send(1, 8'hA5, 1'b0);
        capture(1, 48);
        check("8e1_bits",    frame_bits(0, 11), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
        check("8e1_done_at", done_at, 32'd44);
        send(2, 8'hA5, 1'b0);
        capture(2, 48);
        check("8o1_bits",    frame_bits(0, 11), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
        check("8o1_done_at", done_at, 32'd44);

        // Back-to-back: 0x00 then 0xFF, valid held; data changes right after accept
        send(0, 8'h00, 1'b1);
        r_data = 8'hFF;
        capture(0, 84);
        check("b2b_frame1",    frame_bits(0, 10), 32'({1'b1, 8'h00, 1'b0}));
        check("b2b_stop_high", 32'(trace[43]), 32'd1);
        check("b2b_start2",    32'(trace[44]), 32'd0);
        check("b2b_frame2",    frame_bits(44, 10), 32'({1'b1, 8'hFF, 1'b0}));
        check("b2b_ready_cnt", ready_cnt, 32'd1);
        check("b2b_done_at",   done_at,   32'd40);
        check("b2b_done_cnt",  done_cnt,  32'd1);
        @(negedge clk);
        r_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_idle", 32'(w_busy[0]), 32'd0);

        // tx_en low for 20 cycles during data bit 3
        send(0, 8'hA5, 1'b0);
        wait_fall(0, ok);
        check("pause_fall", 32'(ok), 32'd1);
        hold_err   = 0;
        done_cnt   = 0;
        done_at    = -1;
        obs        = '0;
        pause_busy = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c >= 18 && c <= 37 && w_tx[0] !== 1'b0) hold_err++;
            if (c == 30) pause_busy = w_busy[0];
            if (w_done[0] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            for (int i = 0; i < 10; i++) if (c == pause_point(i)) obs[i] = w_tx[0];
            if (c == 17) r_tx_en = 1'b0;
            if (c == 37) r_tx_en = 1'b1;
        end
        check("pause_hold",     hold_err, 32'd0);
        check("pause_busy",     32'(pause_busy), 32'd1);
        check("pause_bits",     obs, 32'({1'b1, 8'hA5, 1'b0}));
        check("pause_done_at",  done_at,  32'd60);
        check("pause_done_cnt", done_cnt, 32'd1);

        // Reset during data bit 5 of 0x5A (bit 5 is 0, so tx is low)
        send(0, 8'h5A, 1'b0);
        wait_fall(0, ok);
        check("rstmid_fall", 32'(ok), 32'd1);
        repeat (25) @(negedge clk);
        check("rstmid_pre_tx", 32'(w_tx[0]), 32'd0);
        r_reset = 1'b1;
        @(negedge clk);
        check("rstmid_tx",    32'(w_tx[0]),    32'd1);
        check("rstmid_busy",  32'(w_busy[0]),  32'd0);
        check("rstmid_done",  32'(w_done[0]),  32'd0);
        check("rstmid_ready", 32'(w_ready[0]), 32'd0);
        repeat (3) @(negedge clk);
        r_reset  = 1'b0;
        done_cnt = 0;
        low_cnt  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (w_done[0] === 1'b1) done_cnt++;
            if (w_tx[0] !== 1'b1) low_cnt++;
        end
        check("rstmid_no_done", done_cnt, 32'd0);
        check("rstmid_line",    low_cnt,  32'd0);
        send(0, 8'h3C, 1'b0);
        capture(0, 44);
        check("post_rst_bits",    frame_bits(0, 10), 32'({1'b1, 8'h3C, 1'b0}));
        check("post_rst_done_at", done_at, 32'd40);

        // 7N2, 0x55
        send(3, 8'h55, 1'b0);
        capture(3, 44);
        check("7n2_bits",     frame_bits(0, 10), 32'({2'b11, 7'h55, 1'b0}));
        check("7n2_done_at",  done_at,  32'd40);
        check("7n2_done_cnt", done_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmit engine placed directly downstream of `bitrate_converter` inside the UART top level. It accepts one data word through a valid/ready handshake and serialises it LSB-first on `tx`. Each frame is a start bit, `DATA_BITS` data bits, an optional parity bit, then `STOP_BITS` stop bits. Every line transition is paced by the single-cycle `t_clk` bit tick and gated by `tx_en`, both of which `bitrate_converter` produces.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `t_clk`  in  1  bit tick; one-cycle-high enable in the `clk_in` domain, not a clock.
- `tx_en`  in  1  transmit enable.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word.
- `tx`  out  1  serial line, registered, idles high.
- `tx_busy`  out  1  a frame is in progress (any state other than IDLE).
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: `tx`=1, `tx_ready`=0 during reset, `tx_busy`=0, `tx_done`=0. State goes to IDLE and all counters clear.
- `tx_ready` = (state==IDLE) & `tx_en`.
- An accept occurs on a cycle where `tx_valid` & `tx_ready` are both high. On accept, `tx_data` is latched into the shift register and the parity bit is computed: even = ^data, odd = ~^data.
- FSM states and transitions. Apart from the IDLE→ARMED accept, every advance needs `t_clk` & `tx_en` and is called a *tick* below.
  - IDLE: on accept → ARMED. `tx` stays 1. Ticks are ignored.
  - ARMED: on tick, `tx`<=0 and go to START.
  - START: on tick, `tx`<=shreg[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on tick:
    - if bit_cnt==DATA_BITS-1: go to PARITY with `tx`<=parity when PARITY≠0; otherwise go to STOP with `tx`<=1 and stop_cnt<=0.
    - otherwise `tx`<=next bit and bit_cnt++.
  - PARITY: on tick, `tx`<=1, stop_cnt<=0, go to STOP.
  - STOP: on tick:
    - if stop_cnt==STOP_BITS-1: go to IDLE and pulse `tx_done`.
    - otherwise stop_cnt++.
- `tx_en` low freezes the FSM and holds `tx`; the frame resumes from the same state when `tx_en` returns high.
- `tx_data` changes after accept have no effect on the current frame.
- Width rules: bit_cnt is $clog2(DATA_BITS) bits wide; stop_cnt is 1 bit wide.

## Timing
- From accept to the start bit on the line, `tx` falls on the first tick after accept. A tick in the accept cycle itself is not used.
- Every bit, start bit included, lasts exactly one tick interval.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick intervals, measured from the falling edge of `tx`.
- `tx_done` is asserted in the cycle after the final stop tick, together with `tx_ready`=1 (when `tx_en`=1).
- Back-to-back frames: if the next accept lands before the next tick, the following start bit begins exactly at that tick, so there is no idle gap.
- Reset mid-frame: at the next edge `tx`=1, state is IDLE, and the frame is discarded with no `tx_done`.
- A tick that coincides with reset is ignored.

## Structure
- Package `uart_pkg` holds:
  - the state enum `tx_state_t` (IDLE, ARMED, START, DATA, PARITY, STOP);
  - the parity constants `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2.
- These are shared with the future `uart_rx`.
- No sub-module: a single FSM with a shift register. `uart_top` instantiates `bitrate_converter` and connects its `t_clk`/`tx_en` outputs to this block.

## Test plan
- Ticks every 4 cycles, 8N1, send 0xA5 → `tx` sequence per tick 0,1,0,1,0,0,1,0,1,1. Single `tx_done` pulse 40 cycles after the start edge.
- Same stimulus with PARITY=1, then PARITY=2, sending 0xA5 → parity bit 0 (even) and 1 (odd). Frame is 11 bits long.
- Two words 0x00 then 0xFF with `tx_valid` held high → second start bit immediately follows the stop bit, and `tx_ready` is high for exactly one cycle between frames.
- `tx_en` dropped for 20 cycles during DATA bit 3 → `tx` holds its value, ticks are ignored, and the remaining bits are correct after resume.
- `reset` asserted during bit 5 → `tx`=1 on the next edge, `tx_busy`=0, no `tx_done`; a subsequent 0x3C transmits correctly.
- STOP_BITS=2, DATA_BITS=7, send 0x55 → seven data bits 1,0,1,0,1,0,1 followed by two high tick intervals before IDLE.
